// File: rtl/hazard_bubble_ctrl.sv
// Load-use hazard / branch-flush bubble controller between control unit and ID/EX.
// Optional saturating perf counters are enabled with `define HAZ_PERF_CNT_EN.
module hazard_bubble_ctrl #(
    parameter int                 CTRL_W       = 10,
    parameter logic [CTRL_W-1:0]  BUBBLE_VAL   = '0,
    parameter int                 REG_ADDR_W   = 5,
    parameter int                 STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CTRL_W-1:0]     ctrl_in,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  branch_taken,
    output logic [CTRL_W-1:0]     ctrl_out,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  stall,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT =
        (STALL_CYCLES > 1) ? 4'(STALL_CYCLES - 2) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       haz, haz_active, bubble;

    assign haz = ex_mem_read && (ex_rt != '0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign haz_active = ((state_q == IDLE) && haz) || (state_q == STALL);
    assign bubble     = branch_taken || haz_active;

    // Reset forces the safe pattern: bubble out, front end frozen, no flush.
    always_comb begin
        ctrl_out    = bubble ? BUBBLE_VAL : ctrl_in;
        pc_write    = ~(haz_active & ~branch_taken);
        if_id_write = ~(haz_active & ~branch_taken);
        if_id_flush = branch_taken;
        stall       = haz_active & ~branch_taken;
        if (rst) begin
            ctrl_out    = BUBBLE_VAL;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b0;
            stall       = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (branch_taken) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (haz && (STALL_CYCLES > 1)) begin
                        state_d = STALL;
                        cnt_d   = CNT_INIT;
                    end
                end
                STALL: begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (if_id_flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule
